// File: rtl/fp_mul_normalize.sv
// Normalize, round and pack stage of the binary32 multiplier: IDLE -> NORM -> ROUND -> HOLD.
// Define FPM_RNE_ROUND_EN for round-to-nearest-even; otherwise the mantissa is truncated.
module fp_mul_normalize (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [47:0] in_prod,
    input  logic [9:0]  in_exp,
    input  logic        in_sign,
    input  logic        in_zero,
    input  logic        in_inf,
    input  logic        in_nan,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_result,
    output logic        out_ovf,
    output logic        out_unf,
    output logic        out_inexact
);

    typedef enum logic [1:0] {S_IDLE, S_NORM, S_ROUND, S_HOLD} state_t;

    state_t             state_q, state_d;
    logic [47:0]        prod_q, prod_d;
    logic signed [9:0]  exp_q, exp_d;
    logic               sign_q, sign_d;
    logic               zero_q, zero_d;
    logic               inf_q, inf_d;
    logic               nan_q, nan_d;
    logic               prod_zero_q, prod_zero_d;
    logic [22:0]        man_q, man_d;
    logic               guard_q, guard_d;
    logic               sticky_q, sticky_d;
    logic               in_ready_q, in_ready_d;
    logic               out_valid_q, out_valid_d;
    logic [31:0]        result_q, result_d;
    logic               ovf_q, ovf_d;
    logic               unf_q, unf_d;
    logic               inexact_q, inexact_d;

    logic               round_up;
    logic [23:0]        man_sum;
    logic signed [9:0]  exp_r;
    logic               inexact_r;

    always_comb begin
        state_d     = state_q;
        prod_d      = prod_q;
        exp_d       = exp_q;
        sign_d      = sign_q;
        zero_d      = zero_q;
        inf_d       = inf_q;
        nan_d       = nan_q;
        prod_zero_d = prod_zero_q;
        man_d       = man_q;
        guard_d     = guard_q;
        sticky_d    = sticky_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        result_d    = result_q;
        ovf_d       = ovf_q;
        unf_d       = unf_q;
        inexact_d   = inexact_q;

`ifdef FPM_RNE_ROUND_EN
        round_up  = guard_q & (sticky_q | man_q[0]);
`else
        round_up  = 1'b0;
`endif
        man_sum   = {1'b0, man_q} + {23'd0, round_up};
        exp_r     = exp_q + (man_sum[23] ? 10'sd1 : 10'sd0);
        inexact_r = guard_q | sticky_q;

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    prod_d     = in_prod;
                    exp_d      = $signed(in_exp);
                    sign_d     = in_sign;
                    zero_d     = in_zero;
                    inf_d      = in_inf;
                    nan_d      = in_nan;
                    in_ready_d = 1'b0;
                    state_d    = S_NORM;
                end
            end
            S_NORM: begin
                // A product in [2,4) carries one extra integer bit, so shift one further.
                if (prod_q[47]) begin
                    man_d    = prod_q[46:24];
                    guard_d  = prod_q[23];
                    sticky_d = |prod_q[22:0];
                    exp_d    = exp_q + 10'sd1;
                end else begin
                    man_d    = prod_q[45:23];
                    guard_d  = prod_q[22];
                    sticky_d = |prod_q[21:0];
                end
                prod_zero_d = (prod_q == 48'd0);
                state_d     = S_ROUND;
            end
            S_ROUND: begin
                ovf_d     = 1'b0;
                unf_d     = 1'b0;
                inexact_d = 1'b0;
                if (nan_q) begin
                    result_d = 32'h7FC0_0000;
                end else if (inf_q) begin
                    result_d = {sign_q, 8'hFF, 23'd0};
                end else if (zero_q || prod_zero_q) begin
                    result_d = {sign_q, 31'd0};
                end else if (exp_r >= 10'sd255) begin
                    result_d  = {sign_q, 8'hFF, 23'd0};
                    ovf_d     = 1'b1;
                    inexact_d = 1'b1;
                end else if (exp_r <= 10'sd0) begin
                    result_d  = {sign_q, 31'd0};
                    unf_d     = 1'b1;
                    inexact_d = 1'b1;
                end else begin
                    result_d  = {sign_q, exp_r[7:0], man_sum[22:0]};
                    inexact_d = inexact_r;
                end
                out_valid_d = 1'b1;
                state_d     = S_HOLD;
            end
            S_HOLD: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = S_IDLE;
                end
            end
            default: begin
                state_d     = S_IDLE;
                in_ready_d  = 1'b1;
                out_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            prod_q      <= '0;
            exp_q       <= '0;
            sign_q      <= 1'b0;
            zero_q      <= 1'b0;
            inf_q       <= 1'b0;
            nan_q       <= 1'b0;
            prod_zero_q <= 1'b0;
            man_q       <= '0;
            guard_q     <= 1'b0;
            sticky_q    <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            ovf_q       <= 1'b0;
            unf_q       <= 1'b0;
            inexact_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            prod_q      <= prod_d;
            exp_q       <= exp_d;
            sign_q      <= sign_d;
            zero_q      <= zero_d;
            inf_q       <= inf_d;
            nan_q       <= nan_d;
            prod_zero_q <= prod_zero_d;
            man_q       <= man_d;
            guard_q     <= guard_d;
            sticky_q    <= sticky_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            ovf_q       <= ovf_d;
            unf_q       <= unf_d;
            inexact_q   <= inexact_d;
        end
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = out_valid_q;
    assign out_result  = result_q;
    assign out_ovf     = ovf_q;
    assign out_unf     = unf_q;
    assign out_inexact = inexact_q;

endmodule

// File: tb/tb_fp_mul_normalize.sv
// Directed and randomized checks of fp_mul_normalize against an arithmetic reference model.
module tb_fp_mul_normalize;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [47:0] in_prod;
    logic [9:0]  in_exp;
    logic        in_sign, in_zero, in_inf, in_nan;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic        out_ovf, out_unf, out_inexact;

    int compared   = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    fp_mul_normalize dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_prod     (in_prod),
        .in_exp      (in_exp),
        .in_sign     (in_sign),
        .in_zero     (in_zero),
        .in_inf      (in_inf),
        .in_nan      (in_nan),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_result  (out_result),
        .out_ovf     (out_ovf),
        .out_unf     (out_unf),
        .out_inexact (out_inexact)
    );

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        compared++;
        assert (obs === expv) else begin
            mismatched++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, expv);
        end
    endtask

    // Reference: scale the integer product, round on the discarded remainder.
    function automatic void model(input logic [47:0] p, input logic signed [9:0] e,
                                  input logic s, input logic z, input logic i, input logic n,
                                  output logic [31:0] r, output logic [2:0] flg);
        longint unsigned pp, sig, rem, half;
        int sh, ee;
        logic inx;
        pp   = 64'(p);
        sh   = p[47] ? 24 : 23;
        ee   = int'(e) + (p[47] ? 1 : 0);
        sig  = pp >> sh;
        rem  = pp & ((64'd1 << sh) - 64'd1);
        half = 64'd1 << (sh - 1);
        inx  = (rem != 0);
`ifdef FPM_RNE_ROUND_EN
        if (rem > half || (rem == half && sig[0])) sig = sig + 1;
        if (sig == (64'd1 << 24)) begin
            sig = 64'd1 << 23;
            ee  = ee + 1;
        end
`endif
        flg = 3'b000;
        if (n)                 r = 32'h7FC0_0000;
        else if (i)            r = {s, 8'hFF, 23'd0};
        else if (z || p == 0)  r = {s, 31'd0};
        else if (ee >= 255) begin r = {s, 8'hFF, 23'd0}; flg = 3'b101; end
        else if (ee <= 0)   begin r = {s, 31'd0};        flg = 3'b011; end
        else begin
            r = {s, 8'(ee), 23'(sig)};
            flg = {1'b0, 1'b0, inx};
        end
    endfunction

    // flg is {ovf, unf, inexact}
    task automatic do_op(input logic [47:0] p, input logic [9:0] e, input logic s,
                         input logic z, input logic i, input logic n,
                         input int hold, input string tag,
                         output logic [31:0] res, output logic [2:0] flg);
        logic [31:0] er;
        logic [2:0]  ef;
        model(p, e, s, z, i, n, er, ef);
        @(negedge clk);
        in_prod = p; in_exp = e; in_sign = s; in_zero = z; in_inf = i; in_nan = n;
        in_valid = 1'b1; out_ready = 1'b0;
        check({tag, "/in_ready_idle"}, 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_prod = {16'($urandom), $urandom}; in_exp = 10'($urandom);
        @(negedge clk);
        check({tag, "/valid_e0"}, 32'(out_valid), 32'd0);
        @(negedge clk);
        check({tag, "/valid_e1"}, 32'(out_valid), 32'd0);
        @(negedge clk);
        check({tag, "/valid_e2"}, 32'(out_valid), 32'd1);
        check({tag, "/result"}, out_result, er);
        check({tag, "/flags"}, {29'd0, out_ovf, out_unf, out_inexact}, {29'd0, ef});
        check({tag, "/in_ready_busy"}, 32'(in_ready), 32'd0);
        res = out_result;
        flg = {out_ovf, out_unf, out_inexact};
        for (int k = 0; k < hold; k++) begin
            in_valid = 1'b1;
            @(negedge clk);
            check({tag, "/hold_result"}, out_result, er);
            check({tag, "/hold_valid"}, 32'(out_valid), 32'd1);
            check({tag, "/hold_in_ready"}, 32'(in_ready), 32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check({tag, "/valid_drop"}, 32'(out_valid), 32'd0);
        check({tag, "/in_ready_back"}, 32'(in_ready), 32'd1);
        out_ready = 1'b0;
        $display("op %s: prod=%012h exp=%0d s=%0b z=%0b i=%0b n=%0b -> %08h flags=%03b (model %08h %03b)",
                 tag, p, $signed(e), s, z, i, n, res, flg, er, ef);
    endtask

    initial begin
        logic [31:0] r;
        logic [2:0]  f;
        logic [47:0] p;
        logic [9:0]  e;
        logic [31:0] exp_rnd1, exp_carry;

`ifdef FPM_RNE_ROUND_EN
        exp_rnd1  = 32'h3F80_0002;
        exp_carry = 32'h4000_0000;
`else
        exp_rnd1  = 32'h3F80_0001;
        exp_carry = 32'h3FFF_FFFF;
`endif
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_prod = '0; in_exp = '0; in_sign = 1'b0; in_zero = 1'b0; in_inf = 1'b0; in_nan = 1'b0;
        repeat (3) @(negedge clk);
        check("reset/in_ready", 32'(in_ready), 32'd1);
        check("reset/out_valid", 32'(out_valid), 32'd0);
        check("reset/result", out_result, 32'd0);
        check("reset/flags", {29'd0, out_ovf, out_unf, out_inexact}, 32'd0);
        rst_n = 1'b1;

        do_op(48'h4000_0000_0000, 10'd127, 1'b0, 1'b0, 1'b0, 1'b0, 0, "one", r, f);
        check("one/const", r, 32'h3F80_0000);
        check("one/flags_const", 32'(f), 32'd0);
        do_op(48'h9000_0000_0000, 10'd127, 1'b0, 1'b0, 1'b0, 1'b0, 1, "1p5sq", r, f);
        check("1p5sq/const", r, 32'h4010_0000);
        do_op(48'h4000_00C0_0000, 10'd127, 1'b0, 1'b0, 1'b0, 1'b0, 0, "rnd_up", r, f);
        check("rnd_up/const", r, exp_rnd1);
        check("rnd_up/inexact", 32'(f), 32'd1);
        do_op(48'h4000_0040_0000, 10'd127, 1'b0, 1'b0, 1'b0, 1'b0, 0, "rnd_tie", r, f);
        check("rnd_tie/const", r, 32'h3F80_0000);
        check("rnd_tie/inexact", 32'(f), 32'd1);
        do_op(48'h7FFF_FFC0_0000, 10'd127, 1'b0, 1'b0, 1'b0, 1'b0, 0, "carry", r, f);
        check("carry/const", r, exp_carry);
        check("carry/inexact", 32'(f), 32'd1);
        do_op(48'h8000_0000_0000, 10'd254, 1'b1, 1'b0, 1'b0, 1'b0, 0, "ovf", r, f);
        check("ovf/const", r, 32'hFF80_0000);
        check("ovf/flags", 32'(f), 32'b101);
        do_op(48'h4000_0000_0000, 10'd0, 1'b0, 1'b0, 1'b0, 1'b0, 0, "unf", r, f);
        check("unf/const", r, 32'h0000_0000);
        check("unf/flags", 32'(f), 32'b011);
        do_op(48'h4000_0000_0000, 10'd127, 1'b0, 1'b0, 1'b0, 1'b1, 0, "nan", r, f);
        check("nan/const", r, 32'h7FC0_0000);
        do_op(48'h4000_0000_0001, 10'd127, 1'b1, 1'b0, 1'b1, 1'b0, 0, "inf", r, f);
        check("inf/const", r, 32'hFF80_0000);
        do_op(48'h0, 10'd127, 1'b1, 1'b0, 1'b0, 1'b0, 0, "prod0", r, f);
        check("prod0/const", r, 32'h8000_0000);
        do_op(48'h6000_0000_1234, 10'd100, 1'b0, 1'b0, 1'b0, 1'b0, 5, "backpressure", r, f);

        // Reset while the accepted operation sits in NORM.
        @(negedge clk);
        in_prod = 48'h4000_0000_0000; in_exp = 10'd127; in_valid = 1'b1;
        in_zero = 1'b0; in_inf = 1'b0; in_nan = 1'b0; in_sign = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("rst_mid/in_ready_busy", 32'(in_ready), 32'd0);
        #1 rst_n = 1'b0;
        #1;
        check("rst_mid/in_ready", 32'(in_ready), 32'd1);
        check("rst_mid/out_valid", 32'(out_valid), 32'd0);
        check("rst_mid/result", out_result, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) begin
            @(negedge clk);
            check("rst_mid/no_output", 32'(out_valid), 32'd0);
        end
        $display("op rst_mid: reset during NORM, operation discarded");

        for (int t = 0; t < 60; t++) begin
            p = {16'($urandom), $urandom};
            if (p[47:46] == 2'b00) p[46] = 1'b1;
            if ($urandom_range(0, 3) == 0) p[21:0] = '0;
            e = 10'($urandom_range(0, 300)) - 10'd20;
            do_op(p, e, 1'($urandom), $urandom_range(0, 15) == 0, $urandom_range(0, 15) == 0,
                  $urandom_range(0, 15) == 0, $urandom_range(0, 3), $sformatf("rand%0d", t), r, f);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/fp_mul_normalize.md
# fp_mul_normalize

Post-multiply normalize, round and pack stage of the single-precision floating-point multiplier. It consumes the 48-bit mantissa product from the shift-add multiplier, together with the pre-computed sign, biased exponent sum and special-case flags. It produces a packed IEEE-754 binary32 result and status flags behind a valid/ready handshake. Denormal outputs are not produced; results flush to zero.

## Interface
- No parameters; widths are fixed for binary32.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `in_valid` in 1: operands on the `in_*` bus are valid.
- `in_ready` out 1: block can accept; high only in IDLE.
- `in_prod` in 48: unsigned mantissa product, format 2.46, range [1,4).
- `in_exp` in 10: signed two's-complement biased exponent sum, computed as ea+eb-127.
- `in_sign` in 1: result sign (sa^sb).
- `in_zero` in 1: an operand is zero.
- `in_inf` in 1: an operand is infinite.
- `in_nan` in 1: NaN operand or inf*0, already resolved upstream.
- `out_valid` out 1: `out_result` and the flags are valid.
- `out_ready` in 1: downstream accepts.
- `out_result` out 32: packed binary32.
- `out_ovf` out 1: overflow to infinity.
- `out_unf` out 1: underflow flushed to zero.
- `out_inexact` out 1: any discarded product bit was nonzero.

## Operation
- FSM states and transitions:
  - IDLE → NORM when `in_valid & in_ready`; all inputs are captured at that edge.
  - NORM → ROUND unconditionally.
  - ROUND → HOLD unconditionally.
  - HOLD → IDLE when `out_ready`.
- NORM (selection keyed on `prod[47]`):
  - If `prod[47]=1`: mantissa = prod[46:24], guard = prod[23], sticky = OR of prod[22:0], exp = in_exp+1.
  - Else: mantissa = prod[45:23], guard = prod[22], sticky = OR of prod[21:0], exp = in_exp.
- ROUND:
  - Round-to-nearest-even: increment the mantissa when guard & (sticky | mantissa[0]).
  - On carry-out, mantissa becomes 0 and exp increments.
  - `inexact` = guard | sticky.
- Pack priority, first match wins:
  1. nan → 0x7FC00000.
  2. inf → {sign, 0xFF, 0}.
  3. zero or prod==0 → {sign, 31'b0}.
  4. exp ≥ 255 → {sign, 0xFF, 0}, ovf=1, inexact=1.
  5. exp ≤ 0 → {sign, 31'b0}, unf=1, inexact=1.
  6. Otherwise {sign, exp[7:0], mantissa}.
- Flags are 0 for special-case results (nan, inf, zero).
- Exponent arithmetic is 10-bit signed; the +1 from normalization and the +1 from round carry cannot overflow 10 bits for legal inputs.

## Timing
- Reset values: state IDLE, `in_ready`=1, `out_valid`=0, `out_result`=0, all flags 0.
- Latency: handshake accepted at edge E; `out_valid`=1 after edge E+2.
- Outputs are stable while `out_valid & !out_ready`.
- `out_valid` drops at the edge where `out_ready` is sampled high.
- Minimum initiation interval is 4 cycles. `in_ready` returns high the cycle after output acceptance; no bypass from HOLD straight to NORM.
- `in_valid` while not in IDLE is ignored; no capture occurs.
- `rst_n` low mid-operation: immediate return to IDLE with reset output values; the in-flight operation is discarded.

## Configuration
- Macro `FPM_RNE_ROUND_EN`:
  - Defined: ROUND applies round-to-nearest-even as above.
  - Undefined: ROUND truncates; the mantissa is never incremented and no round carry exists. `inexact` and the exp-based ovf/unf rules still apply, and the state sequence and latency are unchanged.

## Test plan
- 1.0×1.0: prod=0x400000000000, exp=127 → 0x3F800000, flags 0, `out_valid` 2 edges after accept.
- 1.5×1.5: prod=0x900000000000, exp=127 → 0x40100000, flags 0.
- Rounding, exp=127:
  - prod=0x400000C00000 → 0x3F800002, inexact=1 (0x3F800001 without `FPM_RNE_ROUND_EN`).
  - prod=0x400000400000 → 0x3F800000, inexact=1.
- Round carry: prod=0x7FFFFFC00000, exp=127 → 0x40000000, inexact=1 (0x3FFFFFFF without the macro).
- Limits:
  - prod=0x800000000000, exp=254, sign=1 → 0xFF800000, ovf=1.
  - prod=0x400000000000, exp=0 → 0x00000000, unf=1.
  - in_nan=1 → 0x7FC00000.
- Backpressure and reset:
  - Hold `out_ready`=0 for 5 cycles: result stable and `in_ready`=0 throughout.
  - Assert `rst_n`=0 during NORM: `out_valid` stays 0 and `in_ready`=1 immediately.
